pdm_frame_ctrl: RTL and testbench

- Sequences the PDM microphone front end for the DP_MFC pipeline.
- Generates the microphone bit clock sclk from clk and gates capture with en.
- Collects 16-bit PCM samples from the PDM decimator (dv/dat_o) into a circular buffer.
- Schedules overlapping analysis frames (FRAME_LEN samples, hop FRAME_SHIFT) and streams each one to the MFCC datapath over a valid/ready handshake.

---
 rtl/pdm_frame_ctrl_if.sv | 23 ++
 rtl/pdm_frame_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_pdm_frame_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_frame_ctrl_if.sv
// Bus bundle for the PDM frame controller: decimator sample strobe in,
// framed sample stream out with valid/ready flow control.
interface pdm_frame_ctrl_if;
  logic               pcm_dv;
  logic signed [15:0] pcm_dat;
  logic               frm_start;
  logic               frm_valid;
  logic signed [15:0] frm_dat;
  logic               frm_last;
  logic               frm_ready;

  // Frame controller side.
  modport master (
    input  pcm_dv, pcm_dat, frm_ready,
    output frm_start, frm_valid, frm_dat, frm_last
  );

  // Decimator / MFCC datapath side.
  modport slave (
    output pcm_dv, pcm_dat, frm_ready,
    input  frm_start, frm_valid, frm_dat, frm_last
  );
endinterface

// File: rtl/pdm_frame_ctrl.sv
// PDM front-end sequencer: generates the microphone bit clock, stores PCM
// samples in a circular buffer and streams overlapping analysis frames
// (FRAME_LEN samples, hop FRAME_SHIFT) to the MFCC datapath.
module pdm_frame_ctrl #(
  parameter int SCLK_HALF   = 32'sd12,
  parameter int FRAME_LEN   = 32'sd256,
  parameter int FRAME_SHIFT = 32'sd128,
  parameter int BUF_AW      = 32'sd9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             sclk,
  pdm_frame_ctrl_if.master fb,
  output logic             busy,
  output logic             overrun
);

  localparam int DEPTH = 32'sd1 << BUF_AW;
  localparam int DIV_W = (SCLK_HALF > 32'sd1) ? $clog2(SCLK_HALF) : 32'sd1;
  localparam int CNT_W = $clog2(FRAME_LEN + 32'sd1);

  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(SCLK_HALF - 32'sd1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  LEN_CNT   = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  SHIFT_CNT = CNT_W'(FRAME_SHIFT);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_LEN - 32'sd1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BUF_AW-1:0] SHIFT_PTR = BUF_AW'(FRAME_SHIFT);
  localparam logic [BUF_AW-1:0] PTR_ONE   = {{(BUF_AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_WAIT = 2'd2,
    ST_READ = 2'd3
  } state_t;

  state_t             state_r;
  logic [DIV_W-1:0]   div_r;
  logic               sclk_r;
  logic [BUF_AW-1:0]  wr_ptr_r;
  logic [BUF_AW-1:0]  base_r;
  logic [BUF_AW-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]   new_cnt_r;
  logic [CNT_W-1:0]   iss_cnt_r;
  logic               frm_start_r;
  logic               frm_valid_r;
  logic signed [15:0] frm_dat_r;
  logic               frm_last_r;
  logic               busy_r;
  logic               overrun_r;
  logic signed [15:0] mem_r [DEPTH];

  logic               wr_s;
  logic               wr_en_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               load_s;
  logic               beat_s;
  logic               last_beat_s;

  // A sample counts only while capture is enabled; IDLE discards it.
  assign wr_s        = fb.pcm_dv & en;
  assign wr_en_s     = wr_s & (state_r != ST_IDLE);
  assign cnt_inc_s   = {{(CNT_W-1){1'b0}}, wr_s};
  // Prefetch the next sample whenever the output register is empty or being
  // consumed, until the whole frame has been issued.
  assign load_s      = (state_r == ST_READ) && (iss_cnt_r != LEN_CNT) &&
                       (!frm_valid_r || fb.frm_ready);
  assign beat_s      = frm_valid_r & fb.frm_ready;
  assign last_beat_s = beat_s & frm_last_r;

  assign sclk         = sclk_r;
  assign busy         = busy_r;
  assign overrun      = overrun_r;
  assign fb.frm_start = frm_start_r;
  assign fb.frm_valid = frm_valid_r;
  assign fb.frm_dat   = frm_dat_r;
  assign fb.frm_last  = frm_last_r;

  // Bit-clock divider: toggle sclk every SCLK_HALF cycles while enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r  <= {DIV_W{1'b0}};
      sclk_r <= 1'b0;
    end else if (!en) begin
      div_r  <= {DIV_W{1'b0}};
      sclk_r <= 1'b0;
    end else if (div_r == DIV_MAX) begin
      div_r  <= {DIV_W{1'b0}};
      sclk_r <= ~sclk_r;
    end else begin
      div_r  <= div_r + DIV_ONE;
    end
  end

  // Circular sample buffer write port (no reset: contents are don't-care).
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= fb.pcm_dat;
    end
  end

  // Frame scheduler and stream output pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= {BUF_AW{1'b0}};
      base_r      <= {BUF_AW{1'b0}};
      rd_ptr_r    <= {BUF_AW{1'b0}};
      new_cnt_r   <= {CNT_W{1'b0}};
      iss_cnt_r   <= {CNT_W{1'b0}};
      frm_start_r <= 1'b0;
      frm_valid_r <= 1'b0;
      frm_dat_r   <= 16'sd0;
      frm_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frm_start_r <= 1'b0;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end

      case (state_r)
        ST_IDLE: begin
          wr_ptr_r  <= {BUF_AW{1'b0}};
          base_r    <= {BUF_AW{1'b0}};
          new_cnt_r <= {CNT_W{1'b0}};
          if (en) begin
            state_r <= ST_FILL;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end

        ST_FILL: begin
          if (!en) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (new_cnt_r == LEN_CNT) begin
            state_r     <= ST_READ;
            rd_ptr_r    <= base_r;
            new_cnt_r   <= cnt_inc_s;
            iss_cnt_r   <= {CNT_W{1'b0}};
            frm_start_r <= 1'b1;
          end else begin
            new_cnt_r <= new_cnt_r + cnt_inc_s;
          end
        end

        ST_WAIT: begin
          if (!en) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (new_cnt_r == SHIFT_CNT) begin
            state_r     <= ST_READ;
            base_r      <= base_r + SHIFT_PTR;
            rd_ptr_r    <= base_r + SHIFT_PTR;
            new_cnt_r   <= cnt_inc_s;
            iss_cnt_r   <= {CNT_W{1'b0}};
            frm_start_r <= 1'b1;
          end else begin
            new_cnt_r <= new_cnt_r + cnt_inc_s;
          end
        end

        ST_READ: begin
          // A hop falling due mid-stream is dropped but still advances the
          // frame grid, so later frames stay aligned and unread data is safe.
          if (new_cnt_r == SHIFT_CNT) begin
            overrun_r <= 1'b1;
            base_r    <= base_r + SHIFT_PTR;
            new_cnt_r <= cnt_inc_s;
          end else begin
            new_cnt_r <= new_cnt_r + cnt_inc_s;
          end

          if (load_s) begin
            frm_dat_r   <= mem_r[rd_ptr_r];
            frm_last_r  <= (iss_cnt_r == LAST_IDX);
            frm_valid_r <= 1'b1;
            rd_ptr_r    <= rd_ptr_r + PTR_ONE;
            iss_cnt_r   <= iss_cnt_r + CNT_ONE;
          end else if (beat_s) begin
            frm_valid_r <= 1'b0;
            frm_last_r  <= 1'b0;
            frm_dat_r   <= 16'sd0;
          end

          if (last_beat_s) begin
            state_r <= en ? ST_WAIT : ST_IDLE;
            busy_r  <= en;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_frame_ctrl.sv
// Scoreboard bench for pdm_frame_ctrl: stimulus pushes expected frame beats,
// a negedge monitor pops and compares every accepted beat.
module tb_pdm_frame_ctrl;

  logic clk;
  logic reset;
  logic en;
  logic sclk;
  logic busy;
  logic overrun;

  pdm_frame_ctrl_if fif ();

  pdm_frame_ctrl #(
    .SCLK_HALF  (12),
    .FRAME_LEN  (8),
    .FRAME_SHIFT(4),
    .BUF_AW     (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .sclk   (sclk),
    .fb     (fif),
    .busy   (busy),
    .overrun(overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int starts_seen = 0;
  int cyc = 0;
  int start_cyc = 0;
  int span = 0;
  int rdy_mode = 0;   // 0: ready low, 1: ready high, 2: random
  logic [16:0] exp_q[$]; // {last, data}

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ready();
    case (rdy_mode)
      0:       fif.frm_ready = 1'b0;
      1:       fif.frm_ready = 1'b1;
      default: fif.frm_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One sample slot: pcm_dv strobe, then 24 quiet cycles.
  task automatic feed_sample(input int v);
    for (int c = 0; c < 25; c++) begin
      fif.pcm_dv  = (c == 0);
      fif.pcm_dat = 16'(v);
      drive_ready();
      tick();
    end
    fif.pcm_dv = 1'b0;
  endtask

  task automatic push_frame(input int first);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({(i == 7), 16'(first + i)});
    end
  endtask

  task automatic wait_sclk(input logic val, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sclk !== val && n < 100);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sclk"},      sclk,          0);
    check({tag, "_busy"},      busy,          0);
    check({tag, "_overrun"},   overrun,       0);
    check({tag, "_frm_start"}, fif.frm_start, 0);
    check({tag, "_frm_valid"}, fif.frm_valid, 0);
    check({tag, "_frm_dat"},   fif.frm_dat,   0);
    check({tag, "_frm_last"},  fif.frm_last,  0);
  endtask

  // Monitor: count frame starts and score every accepted beat.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      if (fif.frm_start) begin
        starts_seen = starts_seen + 1;
        start_cyc = cyc;
      end
      if (fif.frm_valid && fif.frm_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: got beat with data %0d, required no beat", fif.frm_dat);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("beat_dat", 32'(fif.frm_dat), 32'(e[15:0]));
          check("beat_last", fif.frm_last, e[16]);
          if (fif.frm_last) span = cyc - start_cyc + 1;
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    int n;
    int highs;
    reset = 1'b0;
    en = 1'b0;
    fif.pcm_dv = 1'b0;
    fif.pcm_dat = 16'sd0;
    fif.frm_ready = 1'b0;

    // Reset state.
    repeat (3) tick();
    check_all_zero("in_reset");
    reset = 1'b1;
    repeat (2) tick();
    check_all_zero("after_reset");

    // Bit clock.
    en = 1'b1;
    wait_sclk(1'b1, n);
    check("sclk_first_rise", n, 12);
    check("busy_fill", busy, 1);
    wait_sclk(1'b0, n);
    check("sclk_high_half", n, 12);
    wait_sclk(1'b1, n);
    check("sclk_low_half", n, 12);
    en = 1'b0;
    tick();
    check("sclk_forced_low", sclk, 0);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sclk) highs++;
    end
    check("sclk_held_highs", highs, 0);
    en = 1'b1;
    wait_sclk(1'b1, n);
    check("sclk_rise_after_hold", n, 12);
    en = 1'b0;
    repeat (3) tick();

    // Enable drop during FILL discards partial samples.
    rdy_mode = 1;
    en = 1'b1;
    repeat (2) tick();
    for (int v = 1001; v <= 1006; v++) feed_sample(v);
    en = 1'b0;
    repeat (3) tick();
    check("idle_after_en_drop", busy, 0);
    feed_sample(2000);
    check("no_start_partial", starts_seen, 0);
    en = 1'b1;
    repeat (2) tick();

    // First frame 1..8, full-rate stream.
    for (int v = 1; v <= 8; v++) begin
      if (v == 8) push_frame(1);
      feed_sample(v);
    end
    check("starts_first", starts_seen, 1);
    check("span_first", span, 9);
    check("valid_low_wait", fif.frm_valid, 0);
    check("busy_wait", busy, 1);

    // Hops: 5..12, 9..16.
    for (int v = 9; v <= 16; v++) begin
      if (v == 12) push_frame(5);
      if (v == 16) push_frame(9);
      feed_sample(v);
    end
    check("starts_hops", starts_seen, 3);
    check("span_hop", span, 9);
    check("overrun_clean", overrun, 0);

    // Random back-pressure over ten frames.
    rdy_mode = 2;
    for (int v = 17; v <= 56; v++) begin
      if (v % 4 == 0) push_frame(v - 7);
      feed_sample(v);
    end
    rdy_mode = 1;
    fif.frm_ready = 1'b1;
    repeat (30) tick();
    check("starts_random", starts_seen, 13);
    check("overrun_random", overrun, 0);
    check("queue_random", exp_q.size(), 0);

    // Overrun: stall the second frame until a hop is dropped.
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("overrun_cleared", overrun, 0);
    tick();
    for (int v = 1; v <= 8; v++) begin
      if (v == 8) push_frame(1);
      feed_sample(v);
    end
    rdy_mode = 0;
    for (int v = 9; v <= 12; v++) begin
      if (v == 12) push_frame(5);
      feed_sample(v);
    end
    check("stall_valid", fif.frm_valid, 1);
    check("stall_dat", 32'(fif.frm_dat), 5);
    for (int v = 13; v <= 16; v++) feed_sample(v);
    check("overrun_set", overrun, 1);
    check("stall_dat_after_drop", 32'(fif.frm_dat), 5);
    rdy_mode = 1;
    for (int v = 17; v <= 20; v++) begin
      if (v == 20) push_frame(13);
      feed_sample(v);
    end
    check("starts_after_drop", starts_seen, 16);
    check("queue_after_drop", exp_q.size(), 0);

    // Async reset in the middle of a stalled frame.
    rdy_mode = 0;
    for (int v = 21; v <= 24; v++) feed_sample(v);
    check("midread_valid", fif.frm_valid, 1);
    check("midread_dat", 32'(fif.frm_dat), 17);
    check("starts_midread", starts_seen, 17);
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) tick();
    reset = 1'b1;
    repeat (30) tick();
    check("no_resume_valid", fif.frm_valid, 0);
    check("no_resume_starts", starts_seen, 17);
    check("leftover_beats", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
